fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO data and stream data.
REQ-002 Parameter PKT_LEN, default 4, words per output packet; legal range 1 to 256.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_data  input  DATA_WIDTH  upstream FIFO registered read data, valid one cycle after fifo_r_en.
REQ-007 fifo_r_en  output  1  pop request to upstream FIFO.
REQ-008 m_valid  output  1  stream word valid.
REQ-009 m_ready  input  1  downstream accepts word.
REQ-010 m_data  output  DATA_WIDTH  stream word.
REQ-011 m_last  output  1  final word of current packet.
REQ-012 pkt_count  output  16  completed packets since reset.

Function
REQ-013 The block SHALL hold a 2-entry internal buffer with states EMPTY, ONE and TWO, and a 1-bit in-flight flag marking a pop issued in the previous cycle.
REQ-014 fifo_r_en SHALL be combinational: asserted iff !fifo_empty and (occupancy + in-flight + 1) <= 2 after accounting for a same-cycle stream transfer.
REQ-015 The in-flight flag SHALL be set on the cycle after fifo_r_en=1; fifo_data SHALL then be captured into the buffer tail on that cycle's rising edge.
REQ-016 A stream transfer SHALL occur on a cycle with m_valid=1 and m_ready=1; the head entry SHALL then be removed.
REQ-017 m_valid SHALL be 1 iff the buffer is ONE or TWO; m_data SHALL be the head entry; m_data and m_valid SHALL come directly from registers.
REQ-018 m_data and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-019 Simultaneous capture and transfer SHALL leave occupancy unchanged and preserve word order.
REQ-020 Buffer transitions: EMPTY->ONE on capture; ONE->TWO on capture without transfer; ONE->EMPTY on transfer without capture; TWO->ONE on transfer; no capture in TWO.
REQ-021 A word counter, 0 to PKT_LEN-1, SHALL increment on each transfer and wrap to 0 after the transfer at PKT_LEN-1.
REQ-022 m_last SHALL equal (word counter == PKT_LEN-1) and m_valid; with PKT_LEN=1 every word is last.
REQ-023 pkt_count SHALL increment by 1 on each transfer with m_last=1, wrapping from 0xFFFF to 0x0000.
REQ-024 With m_ready held 1 and FIFO never empty, throughput SHALL be one word per cycle after a 2-cycle start latency, from the first fifo_r_en to the first m_valid.
REQ-025 fifo_r_en SHALL never be asserted while fifo_empty=1; words SHALL never be dropped or duplicated.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL clear the buffer to EMPTY, the in-flight flag, the word counter, pkt_count and m_data to 0.
REQ-027 While rst_n=0, fifo_r_en, m_valid and m_last SHALL be 0.
REQ-028 Data returned for a pop issued in the cycle before reset asserts SHALL be discarded, and no word SHALL appear after reset releases.
REQ-029 Reset mid-packet SHALL restart packet framing at word 0.

Verification
REQ-030 Streaming: FIFO preloaded with 0x01..0x08, PKT_LEN=4, m_ready=1 -> m_data 0x01..0x08 on consecutive cycles, m_last on 0x04 and 0x08, pkt_count=2.
REQ-031 Backpressure: m_ready=0 for 5 cycles with FIFO non-empty -> buffer TWO, fifo_r_en=0, m_data holds first word; releasing m_ready drains in order with no loss.
REQ-032 Empty handling: fifo_empty=1 throughout -> fifo_r_en=0 and m_valid=0 on every cycle.
REQ-033 Toggling m_ready (1,0,1,0...) over 12 words -> output sequence equals input sequence and m_last on every 4th word.
REQ-034 Reset mid-operation: rst_n=0 one cycle after fifo_r_en while buffer holds 2 words -> next cycle m_valid=0 and pkt_count=0; after release, the first packet is framed from word 0.
REQ-035 Wrap: force 65536 packets (PKT_LEN=1) -> pkt_count returns to 0x0000.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops an upstream FIFO with registered read data and
// re-frames the words as a valid/ready packet stream with a packet counter.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           pkt_count
);

    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);

    // Encoding doubles as the buffer occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    buf_state_t            state;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  valid_q;
    logic [CW-1:0]         word_idx;
    logic [15:0]           pkt_q;

    logic                  xfer;
    logic                  capture;
    logic                  at_last;
    logic [2:0]            load;

    assign xfer    = valid_q & m_ready;
    assign capture = in_flight;
    assign at_last = (word_idx == LAST_IDX);

    // Words held plus the one still on its way from the FIFO.
    assign load = {1'b0, state} + {2'b00, in_flight};

    // Pop only when the new word is guaranteed a slot on arrival.
    always_comb begin
        fifo_r_en = 1'b0;
        if (rst_n && !fifo_empty) begin
            fifo_r_en = (load <= (3'd1 + {2'b00, xfer}));
        end
    end

    assign m_valid   = valid_q;
    assign m_data    = head;
    assign m_last    = valid_q & at_last;
    assign pkt_count = pkt_q;

    // Buffer FSM, in-flight tracking and packet framing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_flight <= 1'b0;
            head      <= '0;
            tail      <= '0;
            valid_q   <= 1'b0;
            word_idx  <= '0;
            pkt_q     <= '0;
        end else begin
            in_flight <= fifo_r_en;
            unique case (state)
                EMPTY: begin
                    if (capture) begin
                        head    <= fifo_data;
                        state   <= ONE;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (capture && xfer) begin
                        head <= fifo_data;
                    end else if (capture) begin
                        tail  <= fifo_data;
                        state <= TWO;
                    end else if (xfer) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
            if (xfer) begin
                if (at_last) begin
                    word_idx <= '0;
                    pkt_q    <= pkt_q + 16'd1;
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and randomized checks of the FIFO stream
// reader against a packet-level reference model of the output stream.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int PL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_r_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [15:0]   pkt_count;

    logic          rst1_n;
    logic [DW-1:0] fifo1_data = '0;
    logic          fifo1_r_en;
    logic          m1_valid;
    logic [DW-1:0] m1_data;
    logic          m1_last;
    logic [15:0]   pkt1;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .pkt_count(pkt_count)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .fifo_empty(1'b0),
        .fifo_data(fifo1_data), .fifo_r_en(fifo1_r_en), .m_valid(m1_valid),
        .m_ready(1'b1), .m_data(m1_data), .m_last(m1_last),
        .pkt_count(pkt1)
    );

    // Upstream FIFO model: registered read data one cycle after the pop.
    logic [DW-1:0] mem [0:1023];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          hold_empty = 1'b0;

    assign fifo_empty = hold_empty || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Endless counting source for the PKT_LEN=1 instance.
    logic [DW-1:0] d1 = '0;
    always @(posedge clk) begin
        if (!rst1_n) begin
            d1 <= '0;
        end else if (fifo1_r_en) begin
            fifo1_data <= d1;
            d1         <= d1 + 1'b1;
        end
    end

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            exp_idx = 0;
    int            wpos = 0;
    logic [15:0]   pkts = '0;
    logic          stall = 1'b0;
    logic [DW-1:0] stall_data = '0;
    bit            arm_ren = 1'b0;
    int            t_ren = -1;
    int            xq[$];
    logic [DW-1:0] dq[$];
    logic          lq[$];
    int            n1 = 0;
    bit            seen1 = 1'b0;
    int            t1_ren = -1;
    bit            wrap_hit = 1'b0;
    logic [DW-1:0] ref12 [12];
    logic [DW-1:0] post [4];
    int            rd0;
    int            base;
    int            npre;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr[9:0]] = v;
        wr_ptr++;
    endtask

    task automatic clear_log();
        xq.delete();
        dq.delete();
        lq.delete();
    endtask

    // Stream-level model: order of pushes, PKT_LEN framing, packet count.
    task automatic sb();
        if (!rst_n) begin
            exp_idx = rd_ptr;
            wpos    = 0;
            pkts    = '0;
            stall   = 1'b0;
        end else begin
            chk("ren_while_empty", fifo_r_en & fifo_empty, 0);
            chk("m_last", m_last, (m_valid && wpos == PL - 1));
            chk("pkt_count", pkt_count, pkts);
            if (stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, stall_data);
            end
            if (arm_ren && fifo_r_en) begin
                t_ren   = cyc;
                arm_ren = 1'b0;
            end
            if (m_valid && m_ready) begin
                chk("order", m_data, mem[exp_idx[9:0]]);
                chk("no_extra_word", exp_idx < rd_ptr, 1);
                xq.push_back(cyc);
                dq.push_back(m_data);
                lq.push_back(m_last);
                exp_idx++;
                if (wpos == PL - 1) begin
                    wpos = 0;
                    pkts++;
                end else begin
                    wpos++;
                end
            end
            stall      = m_valid && !m_ready;
            stall_data = m_data;
        end
    endtask

    task automatic sb1();
        if (rst1_n) begin
            if (t1_ren < 0 && fifo1_r_en) t1_ren = cyc;
            chk("p1_last", m1_last, m1_valid);
            chk("p1_count", pkt1, n1[15:0]);
            if (seen1) chk("p1_rate", m1_valid, 1);
            if (m1_valid) begin
                if (!seen1) chk("p1_latency", cyc - t1_ren, 2);
                chk("p1_data", m1_data, n1[7:0]);
                if (n1 == 65536 && pkt1 == 16'h0000) wrap_hit = 1'b1;
                n1++;
                seen1 = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb();
        sb1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_xfers(input int n, input int budget);
        for (int k = 0; k < budget && xq.size() < n; k++) tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        rst1_n  = 1'b0;
        m_ready = 1'b0;
        repeat (3) tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_r_en", fifo_r_en, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_m_data", m_data, 0);
        rst_n  = 1'b1;
        rst1_n = 1'b1;

        repeat (10) begin
            tick();
            chk("empty_r_en", fifo_r_en, 0);
            chk("empty_valid", m_valid, 0);
        end

        clear_log();
        m_ready = 1'b1;
        arm_ren = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_xfers(8, 40);
        chk("stream_n", xq.size(), 8);
        if (xq.size() >= 8) begin
            chk("stream_latency", xq[0] - t_ren, 2);
            chk("stream_back2back", xq[7] - xq[0], 7);
            for (int i = 0; i < 8; i++) begin
                chk("stream_data", dq[i], i + 1);
                chk("stream_last", lq[i], (i % 4 == 3));
            end
        end
        chk("stream_pkts", pkt_count, 2);

        clear_log();
        m_ready = 1'b0;
        rd0 = rd_ptr;
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        repeat (5) tick();
        chk("bp_valid", m_valid, 1);
        chk("bp_r_en", fifo_r_en, 0);
        chk("bp_data", m_data, 8'h11);
        chk("bp_popped", rd_ptr - rd0, 2);
        m_ready = 1'b1;
        wait_xfers(8, 40);
        chk("bp_n", xq.size(), 8);
        for (int i = 0; i < xq.size() && i < 8; i++)
            chk("bp_order", dq[i], 8'h11 + i);

        clear_log();
        for (int i = 0; i < 12; i++) begin
            ref12[i] = 8'($urandom);
            push(ref12[i]);
        end
        for (int k = 0; k < 100 && xq.size() < 12; k++) begin
            m_ready = ~m_ready;
            tick();
        end
        m_ready = 1'b1;
        chk("tog_n", xq.size(), 12);
        for (int i = 0; i < xq.size() && i < 12; i++) begin
            chk("tog_data", dq[i], ref12[i]);
            chk("tog_last", lq[i], (i % 4 == 3));
        end
        chk("tog_pkts", pkt_count, 7);

        clear_log();
        base = wr_ptr;
        for (int k = 0; k < 300; k++) begin
            hold_empty = ($urandom_range(3) == 0);
            m_ready    = 1'($urandom_range(1));
            if ($urandom_range(2) == 0 && wr_ptr - base < 80)
                push(8'($urandom));
            tick();
        end
        hold_empty = 1'b0;
        m_ready    = 1'b1;
        wait_xfers(wr_ptr - base, 300);
        chk("rand_all_out", xq.size(), wr_ptr - base);
        chk("rand_drained", rd_ptr, wr_ptr);

        clear_log();
        npre = ((PL - wpos) % PL) + 2;
        for (int i = 0; i < npre; i++) push(8'(8'hA0 + i));
        wait_xfers(npre, 40);
        chk("pre_rst_n", xq.size(), npre);
        m_ready = 1'b0;
        rd0 = rd_ptr;
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        tick();
        tick();
        chk("rc_r_en", fifo_r_en, 0);
        chk("rc_valid", m_valid, 1);
        chk("rc_popped", rd_ptr - rd0, 2);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_pkt", pkt_count, 0);
        chk("rst_mid_last", m_last, 0);
        chk("rst_mid_ren", fifo_r_en, 0);
        chk("rst_mid_data", m_data, 0);
        tick();
        rst_n = 1'b1;
        clear_log();
        m_ready = 1'b1;
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        post[0] = 8'hB3;
        post[1] = 8'hC1;
        post[2] = 8'hC2;
        post[3] = 8'hC3;
        wait_xfers(4, 40);
        chk("post_rst_n", xq.size(), 4);
        for (int i = 0; i < xq.size() && i < 4; i++) begin
            chk("post_rst_data", dq[i], post[i]);
            chk("post_rst_last", lq[i], (i == 3));
        end
        chk("post_rst_pkts", pkt_count, 1);
        chk("post_rst_idle", m_valid, 0);

        for (int k = 0; k < 70000 && n1 < 65540; k++) tick();
        chk("p1_done", n1 >= 65540, 1);
        chk("p1_wrap_zero", wrap_hit, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
